// File: rtl/fft_pkg.sv
// Shared FFT definitions: collector states, default sizes and bin index type.
// Imported by the collector, the SPI FFT slave and the FFT core wrapper.
package fft_pkg;

   localparam int FFT_N_BINS = 32;
   localparam int FFT_IN_W   = 16;
   localparam int FFT_OUT_W  = 32;

   typedef logic [$clog2(FFT_N_BINS)-1:0] bin_idx_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_COLLECT,
      ST_FLUSH,
      ST_DONE
   } coll_state_t;

endpackage

// File: rtl/fft_bin_collector_mag_sq_pipe.sv
// Magnitude-squared unit: registers one accepted bin with its index and
// presents re^2+im^2 for a write one cycle after the handshake.
module mag_sq_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int IDX_W = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    bin_valid,
   input  logic signed [IN_W-1:0]  re,
   input  logic signed [IN_W-1:0]  im,
   input  logic [IDX_W-1:0]        idx,
   output logic                    wr_en,
   output logic [IDX_W-1:0]        wr_idx,
   output logic [OUT_W-1:0]        mag
);

   logic signed [IN_W-1:0]   re_q;
   logic signed [IN_W-1:0]   im_q;
   logic signed [2*IN_W-1:0] re_x;
   logic signed [2*IN_W-1:0] im_x;
   logic signed [2*IN_W-1:0] re_sq;
   logic signed [2*IN_W-1:0] im_sq;
   logic [2*IN_W-1:0]        sum;

   // Stage 1: capture the accepted bin, its index and a write strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en  <= 1'b0;
         wr_idx <= '0;
         re_q   <= '0;
         im_q   <= '0;
      end else begin
         wr_en <= bin_valid;
         if (bin_valid) begin
            re_q   <= re;
            im_q   <= im;
            wr_idx <= idx;
         end
      end
   end

   // Squares of two signed values are non-negative, so the sum is unsigned.
   assign re_x  = (2*IN_W)'(re_q);
   assign im_x  = (2*IN_W)'(im_q);
   assign re_sq = re_x * re_x;
   assign im_sq = im_x * im_x;
   assign sum   = $unsigned(re_sq) + $unsigned(im_sq);
   assign mag   = OUT_W'(sum);

endmodule

// File: rtl/fft_bin_collector.sv
// Collects streamed FFT bins into a magnitude-squared result array and
// flags a complete frame to the SPI slave with a level valid.
module fft_bin_collector
   import fft_pkg::*;
#(
   parameter int N_BINS         = FFT_N_BINS,
   parameter int IN_W           = FFT_IN_W,
   parameter int OUT_W          = FFT_OUT_W,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                   i_Clk,
   input  logic                   i_Rst_L,
   input  logic                   i_New_Samples_Ready,
   output logic                   o_FFT_Start,
   input  logic                   i_Bin_Valid,
   output logic                   o_Bin_Ready,
   input  logic signed [IN_W-1:0] i_Bin_Re,
   input  logic signed [IN_W-1:0] i_Bin_Im,
   input  logic                   i_Bin_Last,
   output logic [OUT_W-1:0]       o_FFT_Output [N_BINS],
   output logic                   o_FFT_Valid,
   output logic                   o_Frame_Err
);

   localparam int IDX_W = (N_BINS > 1) ? $clog2(N_BINS) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   coll_state_t       state;
   logic [IDX_W-1:0]  bin_cnt;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              hs;
   logic              last_idx;
   logic              tmo_hit;
   logic              wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [OUT_W-1:0]  wr_mag;

   assign o_Bin_Ready = (state == ST_COLLECT);
   assign hs          = i_Bin_Valid & o_Bin_Ready;
   assign last_idx    = (bin_cnt == IDX_W'(N_BINS - 1));
   assign tmo_hit     = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   mag_sq_pipe #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .IDX_W (IDX_W)
   ) u_mag (
      .clk       (i_Clk),
      .rst_n     (i_Rst_L),
      .bin_valid (hs),
      .re        (i_Bin_Re),
      .im        (i_Bin_Im),
      .idx       (bin_cnt),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .mag       (wr_mag)
   );

   // Frame sequencing: start pulse, bin counting, framing checks, valid flag.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state       <= ST_IDLE;
         o_FFT_Start <= 1'b0;
         o_FFT_Valid <= 1'b0;
         o_Frame_Err <= 1'b0;
         bin_cnt     <= '0;
         tmo_cnt     <= '0;
      end else begin
         o_FFT_Start <= 1'b0;
         unique case (state)
            ST_IDLE, ST_DONE: begin
               if (i_New_Samples_Ready) begin
                  state       <= ST_START;
                  o_FFT_Start <= 1'b1;
                  o_FFT_Valid <= 1'b0;
                  o_Frame_Err <= 1'b0;
                  bin_cnt     <= '0;
                  tmo_cnt     <= '0;
               end
            end
            ST_START: begin
               state <= ST_COLLECT;
            end
            ST_COLLECT: begin
               tmo_cnt <= tmo_cnt + 1'b1;
               if (tmo_hit) begin
                  o_Frame_Err <= 1'b1;
                  state       <= ST_IDLE;
               end else if (hs) begin
                  bin_cnt <= bin_cnt + 1'b1;
                  if (i_Bin_Last && last_idx) begin
                     state <= ST_FLUSH;
                  end else if (i_Bin_Last || last_idx) begin
                     o_Frame_Err <= 1'b1;
                     state       <= ST_IDLE;
                  end
               end
            end
            ST_FLUSH: begin
               // Leave once the final bin's write has landed.
               if (!wr_en) begin
                  o_FFT_Valid <= 1'b1;
                  state       <= ST_DONE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Result array: one write per accepted bin, frozen otherwise.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         for (int i = 0; i < N_BINS; i++) begin
            o_FFT_Output[i] <= '0;
         end
      end else if (wr_en) begin
         o_FFT_Output[wr_idx] <= wr_mag;
      end
   end

endmodule

// File: tb/tb_fft_bin_collector.sv
// Self-checking bench for fft_bin_collector: table vectors, random frames
// with gaps, framing errors, timeout, async reset and retrigger.
module tb_fft_bin_collector;

   localparam int NB = 32;
   localparam int IW = 16;
   localparam int OW = 32;

   typedef struct {
      logic signed [IW-1:0] re;
      logic signed [IW-1:0] im;
      logic [OW-1:0]        exp;
   } vec_t;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 nsr = 1'b0;
   logic                 start;
   logic                 bvalid = 1'b0;
   logic                 bready;
   logic signed [IW-1:0] bre = '0;
   logic signed [IW-1:0] bim = '0;
   logic                 blast = 1'b0;
   logic [OW-1:0]        fout [NB];
   logic                 fvalid;
   logic                 ferr;

   int checks = 0;
   int errors = 0;
   int starts = 0;

   logic signed [IW-1:0] fr_re [NB];
   logic signed [IW-1:0] fr_im [NB];
   vec_t tbl [8];

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (start) starts++;
   end

   fft_bin_collector dut (
      .i_Clk               (clk),
      .i_Rst_L             (rst_n),
      .i_New_Samples_Ready (nsr),
      .o_FFT_Start         (start),
      .i_Bin_Valid         (bvalid),
      .o_Bin_Ready         (bready),
      .i_Bin_Re            (bre),
      .i_Bin_Im            (bim),
      .i_Bin_Last          (blast),
      .o_FFT_Output        (fout),
      .o_FFT_Valid         (fvalid),
      .o_Frame_Err         (ferr)
   );

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic longint model(input int k);
      longint r;
      longint i;
      r = longint'(fr_re[k]);
      i = longint'(fr_im[k]);
      return r * r + i * i;
   endfunction

   task automatic fill_random();
      for (int k = 0; k < NB; k++) begin
         fr_re[k] = IW'($urandom);
         fr_im[k] = IW'($urandom);
      end
   endtask

   // Pulse new-samples at a negedge and wait (bounded) for bin ready.
   task automatic start_frame(output bit ok, output logic st1,
                              output logic v1);
      @(negedge clk) nsr = 1'b1;
      @(negedge clk) nsr = 1'b0;
      st1 = start;
      v1  = fvalid;
      ok  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (bready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Offer bins 0..nb-1, i_Bin_Last on index last_at, optional gaps.
   task automatic stream(input int nb, input int last_at, input bit gaps);
      int  k;
      int  guard;
      bit  hs;
      k = 0;
      guard = 0;
      while (k < nb && guard < 2000) begin
         bvalid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         bre    = fr_re[k];
         bim    = fr_im[k];
         blast  = (k == last_at);
         hs     = bvalid && bready;
         @(posedge clk);
         @(negedge clk);
         if (hs) k++;
         guard++;
      end
      bvalid = 1'b0;
      blast  = 1'b0;
      if (guard >= 2000) chk("stream_bound", k, nb);
   endtask

   task automatic finish_frame(input bit gaps);
      int s0;
      s0 = starts;
      stream(NB, NB - 1, gaps);
      chk("valid_at_T", fvalid, 0);
      @(negedge clk);
      chk("valid_at_T1", fvalid, 0);
      @(negedge clk);
      chk("valid_at_T2", fvalid, 1);
      chk("err_good", ferr, 0);
      chk("ready_done", bready, 0);
      chk("no_extra_start", starts - s0, 0);
      for (int k = 0; k < NB; k++) begin
         chk($sformatf("bin%0d", k), fout[k], model(k));
      end
   endtask

   task automatic good_frame(input bit gaps);
      bit   ok;
      logic st1;
      logic v1;
      int   s0;
      s0 = starts;
      start_frame(ok, st1, v1);
      chk("ready_after_start", ok, 1);
      chk("start_once", starts - s0, 1);
      finish_frame(gaps);
   endtask

   task automatic bad_frame(input string nm, input int nb, input int last_at);
      bit   ok;
      logic st1;
      logic v1;
      fill_random();
      start_frame(ok, st1, v1);
      chk({nm, "_ready"}, ok, 1);
      stream(nb, last_at, 1'b1);
      chk({nm, "_err"}, ferr, 1);
      chk({nm, "_valid"}, fvalid, 0);
      repeat (3) @(negedge clk);
      chk({nm, "_idle_ready"}, bready, 0);
      chk({nm, "_err_held"}, ferr, 1);
   endtask

   initial begin
      bit   ok;
      logic st1;
      logic v1;
      int   nz;

      tbl[0] = '{-16'sd32768, -16'sd32768, 32'h8000_0000};
      tbl[1] = '{ 16'sd32767,  16'sd0,     32'h3FFF_0001};
      tbl[2] = '{ 16'sd0,      16'sd0,     32'h0000_0000};
      tbl[3] = '{ 16'sd1,     -16'sd1,     32'h0000_0002};
      tbl[4] = '{-16'sd1,     -16'sd32768, 32'h4000_0001};
      tbl[5] = '{ 16'sd100,    16'sd200,   32'd50000};
      tbl[6] = '{-16'sd300,    16'sd400,   32'd250000};
      tbl[7] = '{ 16'sd32767,  16'sd32767, 32'h7FFE_0002};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_start", start, 0);
      chk("rst_ready", bready, 0);
      chk("rst_valid", fvalid, 0);
      chk("rst_err", ferr, 0);
      nz = 0;
      for (int k = 0; k < NB; k++) if (fout[k] != '0) nz++;
      chk("rst_array", nz, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal frame: re=k, im=-k
      for (int k = 0; k < NB; k++) begin
         fr_re[k] = IW'(k);
         fr_im[k] = IW'(-k);
      end
      good_frame(1'b0);
      chk("nominal_bin31", fout[31], 1922);

      // Table vectors in the first bins, random elsewhere
      fill_random();
      for (int i = 0; i < 8; i++) begin
         fr_re[i] = tbl[i].re;
         fr_im[i] = tbl[i].im;
      end
      good_frame(1'b0);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("tbl%0d", i), fout[i], tbl[i].exp);
      end

      // Retrigger while in DONE
      chk("done_before_retrig", fvalid, 1);
      fill_random();
      start_frame(ok, st1, v1);
      chk("retrig_valid_drop", v1, 0);
      chk("retrig_start", st1, 1);
      chk("retrig_ready", ok, 1);
      finish_frame(1'b1);

      // Random frames with gaps
      for (int f = 0; f < 3; f++) begin
         fill_random();
         good_frame(1'b1);
      end

      // Short frame then recovery
      bad_frame("short", 21, 20);
      fill_random();
      good_frame(1'b1);

      // Long frame then recovery
      bad_frame("long", NB, -1);
      fill_random();
      good_frame(1'b0);

      // Timeout: no bins for 4096 collect cycles
      start_frame(ok, st1, v1);
      chk("tmo_ready", ok, 1);
      repeat (4095) @(negedge clk);
      chk("tmo_err_early", ferr, 0);
      chk("tmo_ready_early", bready, 1);
      @(negedge clk);
      chk("tmo_err", ferr, 1);
      chk("tmo_ready_drop", bready, 0);
      chk("tmo_valid", fvalid, 0);
      fill_random();
      good_frame(1'b1);

      // Asynchronous reset mid-collect
      fill_random();
      start_frame(ok, st1, v1);
      stream(10, -1, 1'b0);
      chk("pre_rst_ready", bready, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ready", bready, 0);
      chk("arst_start", start, 0);
      chk("arst_valid", fvalid, 0);
      chk("arst_err", ferr, 0);
      nz = 0;
      for (int k = 0; k < NB; k++) if (fout[k] != '0) nz++;
      chk("arst_array", nz, 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      fill_random();
      good_frame(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
